// File: rtl/pipe_stage_skid_reg.sv
// Handshaked pipeline stage register with an optional skid entry, stall/flush
// handling, occupancy report and a saturating bubble counter.
module pipe_stage_skid_reg #(
    parameter int DATA_W    = 140,
    parameter int STALL_W   = 6,
    parameter int STALL_BIT = 2,
    parameter int SKID      = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    input  logic [STALL_W-1:0] stall_in,
    input  logic               up_valid_in,
    input  logic [DATA_W-1:0]  up_data_in,
    output logic               up_ready_out,
    output logic               dn_valid_out,
    output logic [DATA_W-1:0]  dn_data_out,
    input  logic               dn_ready_in,
    output logic [1:0]         occupancy_out,
    output logic [CNT_W-1:0]   bubble_cnt_out
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] skid_data;
    logic [CNT_W-1:0]  bubble_cnt;

    logic hold;
    logic next_hold;
    logic eff_dn_ready;
    logic out_valid;
    logic skid_valid;
    logic room;
    logic up_fire;
    logic dn_fire;
    logic unused_stall;

    assign hold         = stall_in[STALL_BIT];
    assign next_hold    = stall_in[STALL_BIT+1];
    assign unused_stall = ^stall_in;
    assign eff_dn_ready = dn_ready_in & ~next_hold;
    assign out_valid    = (state != EMPTY);
    assign skid_valid   = (state == FULL);

    // With a skid entry ready only looks at local state, breaking the path from dn_ready_in.
    always_comb begin
        room = 1'b0;
        if (SKID != 0)
            room = ~skid_valid;
        else
            room = ~out_valid | eff_dn_ready;
        up_ready_out = rst_in & rdy_in & ~hold & room;
    end

    assign up_fire = up_valid_in & up_ready_out;
    assign dn_fire = out_valid & eff_dn_ready;

    // Entries are zeroed whenever they become invalid, so dn_data_out is zero when not valid.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= EMPTY;
            out_data   <= '0;
            skid_data  <= '0;
            bubble_cnt <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                state     <= EMPTY;
                out_data  <= '0;
                skid_data <= '0;
            end else begin
                if (!out_valid && eff_dn_ready && bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                case (state)
                    EMPTY: begin
                        if (up_fire) begin
                            state    <= ONE;
                            out_data <= up_data_in;
                        end
                    end
                    ONE: begin
                        if (up_fire && dn_fire) begin
                            out_data <= up_data_in;
                        end else if (up_fire && SKID != 0) begin
                            state     <= FULL;
                            skid_data <= up_data_in;
                        end else if (dn_fire) begin
                            state    <= EMPTY;
                            out_data <= '0;
                        end
                    end
                    FULL: begin
                        if (dn_fire) begin
                            state     <= ONE;
                            out_data  <= skid_data;
                            skid_data <= '0;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        out_data  <= '0;
                        skid_data <= '0;
                    end
                endcase
            end
        end
    end

    assign dn_valid_out   = out_valid;
    assign dn_data_out    = out_data;
    assign occupancy_out  = state;
    assign bubble_cnt_out = bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed vector table, randomized traffic
// against a queue model, counter saturation and asynchronous reset.
module tb_pipe_stage_skid_reg;

    localparam int DATA_W = 140;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              flush_in;
    logic [5:0]        stall_in;
    logic              up_valid_in;
    logic [DATA_W-1:0] up_data_in;
    logic              dn_ready_in;

    logic              up_ready_out;
    logic              dn_valid_out;
    logic [DATA_W-1:0] dn_data_out;
    logic [1:0]        occupancy_out;
    logic [15:0]       bubble_cnt_out;

    logic              up_ready4;
    logic              dn_valid4;
    logic [DATA_W-1:0] dn_data4;
    logic [1:0]        occupancy4;
    logic [3:0]        bubble_cnt4;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_q[$];
    int                model_cnt  = 0;
    int                model_cnt4 = 0;

    typedef struct {
        logic              rdy;
        logic              flush;
        logic [5:0]        stall;
        logic              up_valid;
        logic [DATA_W-1:0] data;
        logic              dn_ready;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
        logic [1:0]        exp_occ;
        logic              exp_ready;
    } vec_t;

    vec_t vecs[$];

    pipe_stage_skid_reg dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .stall_in(stall_in), .up_valid_in(up_valid_in), .up_data_in(up_data_in),
        .up_ready_out(up_ready_out), .dn_valid_out(dn_valid_out), .dn_data_out(dn_data_out),
        .dn_ready_in(dn_ready_in), .occupancy_out(occupancy_out), .bubble_cnt_out(bubble_cnt_out)
    );

    pipe_stage_skid_reg #(.CNT_W(4)) dut4 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .stall_in(stall_in), .up_valid_in(up_valid_in), .up_data_in(up_data_in),
        .up_ready_out(up_ready4), .dn_valid_out(dn_valid4), .dn_data_out(dn_data4),
        .dn_ready_in(dn_ready_in), .occupancy_out(occupancy4), .bubble_cnt_out(bubble_cnt4)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    task automatic add_vec(input logic rdy, input logic flush, input logic [5:0] stall,
                           input logic uv, input logic [31:0] d, input logic dr,
                           input logic ev, input logic [31:0] ed, input logic [1:0] eo,
                           input logic er);
        vec_t v;
        v.rdy = rdy; v.flush = flush; v.stall = stall; v.up_valid = uv;
        v.data = DATA_W'(d); v.dn_ready = dr; v.exp_valid = ev;
        v.exp_data = DATA_W'(ed); v.exp_occ = eo; v.exp_ready = er;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic rdy, input logic flush, input logic [5:0] stall,
                                  input logic uv, input logic [DATA_W-1:0] d, input logic dr);
        rdy_in = rdy; flush_in = flush; stall_in = stall;
        up_valid_in = uv; up_data_in = d; dn_ready_in = dr;
    endtask

    // Compares both instances against the queue model's view of the stage.
    task automatic check_output();
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
        logic              exp_ready;
        exp_valid = (model_q.size() > 0);
        exp_data  = exp_valid ? model_q[0] : '0;
        exp_ready = rst_in && rdy_in && !stall_in[2] && (model_q.size() < 2);
        check("dn_valid", DATA_W'(dn_valid_out), DATA_W'(exp_valid));
        check("dn_data", dn_data_out, exp_data);
        check("occupancy", DATA_W'(occupancy_out), DATA_W'(model_q.size()));
        check("up_ready", DATA_W'(up_ready_out), DATA_W'(exp_ready));
        check("bubble_cnt", DATA_W'(bubble_cnt_out), DATA_W'(model_cnt));
        check("dn_data_cnt4", dn_data4, exp_data);
        check("bubble_cnt4", DATA_W'(bubble_cnt4), DATA_W'(model_cnt4));
    endtask

    task automatic model_step();
        logic eff;
        logic dfire;
        logic ufire;
        @(posedge clk_in);
        if (rst_in && rdy_in) begin
            if (flush_in) begin
                model_q.delete();
            end else begin
                eff   = dn_ready_in && !stall_in[3];
                ufire = up_valid_in && !stall_in[2] && (model_q.size() < 2);
                dfire = (model_q.size() > 0) && eff;
                if (model_q.size() == 0 && eff) begin
                    if (model_cnt < 65535) model_cnt++;
                    if (model_cnt4 < 15) model_cnt4++;
                end
                if (dfire) void'(model_q.pop_front());
                if (ufire) model_q.push_back(up_data_in);
            end
        end
        #1;
    endtask

    task automatic run_cycle(input logic rdy, input logic flush, input logic [5:0] stall,
                             input logic uv, input logic [DATA_W-1:0] d, input logic dr);
        apply_stimulus(rdy, flush, stall, uv, d, dr);
        @(negedge clk_in);
        #1;
        check_output();
        model_step();
    endtask

    initial begin
        rst_in = 1'b0;
        apply_stimulus(1'b1, 1'b0, 6'd0, 1'b0, '0, 1'b0);

        // Rows: rdy flush stall up_valid data dn_ready | dn_valid dn_data occupancy up_ready
        add_vec(1,0,6'h00,1,32'h1,1, 0,32'h0,0,1);
        add_vec(1,0,6'h00,1,32'h2,1, 1,32'h1,1,1);
        add_vec(1,0,6'h00,1,32'h3,1, 1,32'h2,1,1);
        add_vec(1,0,6'h00,0,32'h0,1, 1,32'h3,1,1);
        add_vec(1,0,6'h00,1,32'hA,0, 0,32'h0,0,1);
        add_vec(1,0,6'h00,1,32'hB,0, 1,32'hA,1,1);
        add_vec(1,0,6'h00,1,32'hD,0, 1,32'hA,2,0);
        add_vec(1,0,6'h00,0,32'h0,1, 1,32'hA,2,0);
        add_vec(1,0,6'h00,1,32'hE,0, 1,32'hB,1,1);
        add_vec(1,1,6'h00,1,32'hC,0, 1,32'hB,2,0);
        add_vec(1,0,6'h00,0,32'h0,1, 0,32'h0,0,1);
        add_vec(1,0,6'h00,1,32'h5,1, 0,32'h0,0,1);
        add_vec(1,0,6'h04,1,32'h6,1, 1,32'h5,1,0);
        add_vec(1,0,6'h04,1,32'h6,1, 0,32'h0,0,0);
        add_vec(1,0,6'h00,1,32'h7,1, 0,32'h0,0,1);
        add_vec(1,0,6'h0C,0,32'h0,1, 1,32'h7,1,0);
        add_vec(1,0,6'h0C,0,32'h0,1, 1,32'h7,1,0);
        add_vec(0,1,6'h00,1,32'h8,1, 1,32'h7,1,0);
        add_vec(0,0,6'h00,1,32'h8,1, 1,32'h7,1,0);
        add_vec(0,1,6'h00,1,32'h8,1, 1,32'h7,1,0);
        add_vec(1,0,6'h00,1,32'h8,1, 1,32'h7,1,1);
        add_vec(1,0,6'h00,0,32'h0,1, 1,32'h8,1,1);
        add_vec(1,0,6'h00,0,32'h0,1, 0,32'h0,0,1);

        #2;
        check("reset_dn_valid", DATA_W'(dn_valid_out), '0);
        check("reset_occupancy", DATA_W'(occupancy_out), '0);
        check("reset_up_ready", DATA_W'(up_ready_out), '0);
        check_output();
        @(negedge clk_in);
        rst_in = 1'b1;
        model_step();

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].rdy, vecs[i].flush, vecs[i].stall,
                           vecs[i].up_valid, vecs[i].data, vecs[i].dn_ready);
            @(negedge clk_in);
            #1;
            check_output();
            check($sformatf("vec%0d_dn_valid", i), DATA_W'(dn_valid_out), DATA_W'(vecs[i].exp_valid));
            check($sformatf("vec%0d_dn_data", i), dn_data_out, vecs[i].exp_data);
            check($sformatf("vec%0d_occupancy", i), DATA_W'(occupancy_out), DATA_W'(vecs[i].exp_occ));
            check($sformatf("vec%0d_up_ready", i), DATA_W'(up_ready_out), DATA_W'(vecs[i].exp_ready));
            model_step();
        end

        for (int i = 0; i < 400; i++) begin
            run_cycle($urandom_range(0, 9) != 0,
                      $urandom_range(0, 19) == 0,
                      ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
                      1'($urandom_range(0, 1)),
                      rand_data(),
                      $urandom_range(0, 3) != 0);
        end

        // Load a beat, then pull reset between clock edges.
        run_cycle(1'b1, 1'b0, 6'd0, 1'b1, rand_data(), 1'b0);
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_dn_valid", DATA_W'(dn_valid_out), '0);
        check("async_rst_dn_data", dn_data_out, '0);
        check("async_rst_occupancy", DATA_W'(occupancy_out), '0);
        check("async_rst_bubble", DATA_W'(bubble_cnt_out), '0);
        check("async_rst_bubble4", DATA_W'(bubble_cnt4), '0);
        check("async_rst_up_ready", DATA_W'(up_ready_out), '0);
        model_q.delete();
        model_cnt  = 0;
        model_cnt4 = 0;

        apply_stimulus(1'b1, 1'b0, 6'd0, 1'b0, '0, 1'b1);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_step();
        for (int i = 0; i < 19; i++)
            run_cycle(1'b1, 1'b0, 6'd0, 1'b0, '0, 1'b1);
        @(negedge clk_in);
        #1;
        check("idle_bubble_main", DATA_W'(bubble_cnt_out), DATA_W'(20));
        check("idle_bubble_saturated", DATA_W'(bubble_cnt4), DATA_W'(15));
        check_output();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised, handshaked pipeline stage register that replaces the fixed-payload inter-stage latches.
- Carries an opaque payload of DATA_W bits from the upstream stage to the downstream stage using valid/ready.
- Optional skid entry cuts the combinational ready path.
- Honours the global rdy_in gate, the six-bit stall vector and branch flush, and exposes occupancy plus a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 140, payload width in bits (reg1 32 + reg2 32 + pc 32 + imm 32 + rsd 5 + write flag 1 + cmdtype 6).
- STALL_W, 6, width of the stall vector.
- STALL_BIT, 2, index of this stage's hold bit; bit STALL_BIT+1 is the downstream hold. Must satisfy STALL_BIT <= STALL_W-2.
- SKID, 1, 1 = two-entry skid (registered ready); 0 = single entry (combinational ready).
- CNT_W, 16, bubble counter width.

Ports:
- clk_in, input, 1, clock; all state updates on the rising edge.
- rst_in, input, 1, asynchronous active-low reset.
- rdy_in, input, 1, global enable; 0 freezes the block.
- flush_in, input, 1, branch/mispredict flush.
- stall_in, input, STALL_W, stall vector from the stall controller.
- up_valid_in, input, 1, upstream payload valid.
- up_data_in, input, DATA_W, upstream payload.
- up_ready_out, output, 1, stage can accept a beat.
- dn_valid_out, output, 1, output payload valid.
- dn_data_out, output, DATA_W, output payload.
- dn_ready_in, input, 1, downstream accepts.
- occupancy_out, output, 2, number of held entries (0..2).
- bubble_cnt_out, output, CNT_W, saturating count of bubble cycles.

Behaviour:
- Reset (rst_in=0, asynchronous, any time, including mid-transfer):
  - out entry and skid entry invalid, both data fields zero.
  - dn_valid_out=0, dn_data_out=0, occupancy_out=0, bubble_cnt_out=0.
  - up_ready_out=0 while reset is held.
- Definitions:
  - hold = stall_in[STALL_BIT]; next_hold = stall_in[STALL_BIT+1].
  - eff_dn_ready = dn_ready_in & ~next_hold.
  - up_fire = up_valid_in & up_ready_out.
  - dn_fire = dn_valid_out & eff_dn_ready.
- up_ready_out:
  - SKID=1: rdy_in & ~hold & ~skid_valid. Independent of dn_ready_in.
  - SKID=0: rdy_in & ~hold & (~out_valid | eff_dn_ready).
- rdy_in=0: no state, data or counter changes. Inputs, including flush_in, are ignored. Outputs hold their previous values except that up_ready_out=0.
- Priority when rdy_in=1: flush, then normal transfer.
  - Flush: both entries invalidated and zeroed at the edge.
  - A beat presented in the flush cycle is discarded even if up_fire=1.
  - occupancy_out=0 on the next cycle.
  - The bubble counter does not increment in a flush cycle.
- Transfer state machine (state = occupancy):
  - EMPTY:
    - up_fire -> ONE; out entry = up_data_in.
    - Otherwise stay EMPTY, with dn_data_out forced to zero.
  - ONE:
    - up_fire & dn_fire -> ONE; out entry replaced.
    - up_fire & ~dn_fire -> FULL; beat goes to skid (SKID=1 only).
    - ~up_fire & dn_fire -> EMPTY; out entry zeroed.
    - Neither -> hold.
  - FULL (SKID=1 only):
    - dn_fire -> ONE; skid moves to out, skid zeroed.
    - Otherwise hold.
    - up_ready_out=0 in FULL.
- Latency: one cycle from up_fire in EMPTY to dn_valid_out=1. No combinational path from up_data_in to dn_data_out.
- Ordering: beats leave strictly in acceptance order; no duplication or loss except by flush.
- Legacy bubble case: hold=1 and next_hold=0 with out valid and dn_ready_in=1 drains the out entry and then presents a zero payload with dn_valid_out=0.
- dn_data_out is always zero whenever dn_valid_out=0.
- Bubble counter: increments by 1 on each edge where rdy_in=1, flush_in=0, dn_valid_out=0 and eff_dn_ready=1. Saturates at 2^CNT_W-1; no wrap.
- occupancy_out = out_valid + skid_valid, updated at the same edge as the entries.

Test Plan:
- Reset, then stream with dn_ready_in=1: up_valid_in=1 with payloads 0x1, 0x2, 0x3 on consecutive cycles -> dn_data_out shows 0x1, 0x2, 0x3 one cycle later each, and occupancy_out stays 1.
- Backpressure, SKID=1: dn_ready_in=0 while 0xA then 0xB are sent -> occupancy_out=2, up_ready_out=0. Then dn_ready_in=1 -> 0xA, then 0xB are delivered and up_ready_out returns to 1 the cycle after 0xA leaves.
- Flush while FULL with up_valid_in=1 carrying 0xC -> next cycle dn_valid_out=0, dn_data_out=0, occupancy_out=0. 0xC never appears.
- Stall vector: stall_in=6'b000100 with out valid and dn_ready_in=1 -> entry drains, up_ready_out=0, dn_valid_out=0 with zero data. Then stall_in=6'b001100 -> dn_fire suppressed and the entry holds.
- rdy_in=0 for 3 cycles mid-stream with flush_in=1 pulsed -> dn_data_out, occupancy_out and bubble_cnt_out unchanged and the flush is ignored. Streaming resumes losslessly when rdy_in returns to 1.
- CNT_W=4 override, idle for 20 cycles with dn_ready_in=1 -> bubble_cnt_out saturates at 15. Asserting rst_in=0 mid-cycle clears all outputs to 0 without waiting for a clock edge.
